// File: rtl/phy_link_manager.sv
// PHY link manager: brings an Ethernet PHY out of reset over MDIO, writes the
// control register once, then polls BMSR/PSSR and reports link and speed.
module phy_link_manager #(
  parameter int          MDC_DIV    = 10,
  parameter logic [4:0]  PHY_ADDR   = 5'd0,
  parameter int          SETTLE_CYC = 250000,
  parameter int          POLL_CYC   = 500000,
  parameter logic [15:0] CTRL_VAL   = 16'h1340
) (
  input  logic       clk_50_max10,
  input  logic       resetn,
  input  logic       phy_resetn,
  input  logic       restart,
  output logic       mdc,
  output logic       mdio_out,
  output logic       mdio_oen,
  input  logic       mdio_in,
  output logic       link_up,
  output logic [1:0] speed,
  output logic       set_1000,
  output logic       set_10,
  output logic       cfg_done,
  output logic       mdio_err
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] SETTLE    = 3'd1;
  localparam logic [2:0] WR_CTRL   = 3'd2;
  localparam logic [2:0] WAIT_POLL = 3'd3;
  localparam logic [2:0] RD_BMSR   = 3'd4;
  localparam logic [2:0] RD_PSSR   = 3'd5;
  localparam logic [2:0] UPDATE    = 3'd6;

  localparam int CNT_MAX = (SETTLE_CYC > POLL_CYC) ? SETTLE_CYC : POLL_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int DIV_W   = (MDC_DIV > 1) ? $clog2(MDC_DIV + 1) : 1;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] POLL_LAST   = CNT_W'(POLL_CYC - 1);
  localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(MDC_DIV - 1);

  // Full 64-bit management frame; read frames carry 1s after REGAD since the
  // pad is released there anyway.
  function automatic logic [63:0] frame_word(input logic rd, input logic [4:0] regad);
    return {32'hFFFF_FFFF, 2'b01, (rd ? 2'b10 : 2'b01), PHY_ADDR, regad,
            (rd ? 2'b11 : 2'b10), (rd ? 16'hFFFF : CTRL_VAL)};
  endfunction

  // PSSR speed code 11 is reserved and reported as 10M.
  function automatic logic [1:0] map_speed(input logic [1:0] raw);
    return (raw == 2'b11) ? 2'b00 : raw;
  endfunction

  logic [2:0]       state, nxt_state;
  logic [CNT_W-1:0] wait_cnt;
  logic             pend;
  logic             frm_start, frm_act, frm_done, frm_rd, ta_ok;
  logic             nxt_rd;
  logic [4:0]       nxt_reg;
  logic [63:0]      nxt_word;
  logic [DIV_W-1:0] div_cnt;
  logic [5:0]       bit_cnt;
  logic             mdc_rise, mdc_fall;
  logic [62:0]      frm_sh;
  logic [15:0]      rd_sh;
  logic             bmsr_link, bmsr_ok, pssr_link, pssr_ok;
  logic [1:0]       pssr_spd;

  assign mdc_rise = frm_act && (div_cnt == DIV_LAST) && !mdc;
  assign mdc_fall = frm_act && (div_cnt == DIV_LAST) && mdc;

  // Next-state decode; a low phy_resetn overrides everything.
  always_comb begin
    nxt_state = state;
    case (state)
      IDLE:      if (phy_resetn) nxt_state = SETTLE;
      SETTLE:    if (wait_cnt == SETTLE_LAST) nxt_state = WR_CTRL;
      WR_CTRL:   if (frm_done) nxt_state = WAIT_POLL;
      WAIT_POLL: if (pend) nxt_state = WR_CTRL;
                 else if (wait_cnt == POLL_LAST) nxt_state = RD_BMSR;
      RD_BMSR:   if (frm_done) nxt_state = RD_PSSR;
      RD_PSSR:   if (frm_done) nxt_state = UPDATE;
      UPDATE:    nxt_state = WAIT_POLL;
      default:   nxt_state = IDLE;
    endcase
    if (!phy_resetn) nxt_state = IDLE;
  end

  // A frame is launched on the edge that enters one of the frame states.
  always_comb begin
    frm_start = (nxt_state != state) &&
                ((nxt_state == WR_CTRL) || (nxt_state == RD_BMSR) || (nxt_state == RD_PSSR));
    nxt_rd    = (nxt_state != WR_CTRL);
    nxt_reg   = (nxt_state == RD_BMSR) ? 5'd1 : ((nxt_state == RD_PSSR) ? 5'd17 : 5'd0);
    nxt_word  = frame_word(nxt_rd, nxt_reg);
  end

  // Sequencer state, wait counter, restart pending flag and link status outputs.
  always_ff @(posedge clk_50_max10 or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      wait_cnt <= '0;
      pend     <= 1'b0;
      cfg_done <= 1'b0;
      link_up  <= 1'b0;
      speed    <= 2'b00;
      mdio_err <= 1'b0;
    end else begin
      state <= nxt_state;
      if (nxt_state != state)
        wait_cnt <= '0;
      else if ((state == SETTLE) || (state == WAIT_POLL))
        wait_cnt <= wait_cnt + 1'b1;

      if (!phy_resetn) begin
        pend     <= 1'b0;
        cfg_done <= 1'b0;
        link_up  <= 1'b0;
      end else begin
        if ((nxt_state == WR_CTRL) && (state != WR_CTRL)) begin
          pend     <= 1'b0;
          cfg_done <= 1'b0;
        end else if (restart && (state != IDLE) && (state != SETTLE)) begin
          pend <= 1'b1;
        end
        if ((state == WR_CTRL) && frm_done)
          cfg_done <= 1'b1;
        if (state == UPDATE) begin
          if (bmsr_ok && pssr_ok) begin
            link_up  <= bmsr_link & pssr_link;
            speed    <= map_speed(pssr_spd);
            mdio_err <= 1'b0;
          end else begin
            link_up  <= 1'b0;
            mdio_err <= 1'b1;
          end
        end
      end
    end
  end

  // MDC divider and bit sequencing; pad outputs move only when MDC falls.
  always_ff @(posedge clk_50_max10 or negedge resetn) begin
    if (!resetn) begin
      frm_act  <= 1'b0;
      frm_done <= 1'b0;
      frm_rd   <= 1'b0;
      ta_ok    <= 1'b0;
      mdc      <= 1'b0;
      mdio_out <= 1'b1;
      mdio_oen <= 1'b1;
      div_cnt  <= '0;
      bit_cnt  <= '0;
    end else begin
      frm_done <= 1'b0;
      if (!phy_resetn) begin
        frm_act  <= 1'b0;
        mdc      <= 1'b0;
        mdio_out <= 1'b1;
        mdio_oen <= 1'b1;
        div_cnt  <= '0;
        bit_cnt  <= '0;
      end else if (frm_start) begin
        frm_act  <= 1'b1;
        frm_rd   <= nxt_rd;
        ta_ok    <= 1'b0;
        mdc      <= 1'b0;
        mdio_out <= nxt_word[63];
        mdio_oen <= 1'b0;
        div_cnt  <= '0;
        bit_cnt  <= '0;
      end else if (frm_act) begin
        if (div_cnt == DIV_LAST) begin
          div_cnt <= '0;
          mdc     <= ~mdc;
          if (mdc_fall) begin
            if (bit_cnt == 6'd63) begin
              frm_act  <= 1'b0;
              frm_done <= 1'b1;
              mdio_out <= 1'b1;
              mdio_oen <= 1'b1;
              bit_cnt  <= '0;
            end else begin
              bit_cnt  <= bit_cnt + 1'b1;
              mdio_out <= frm_sh[62];
              mdio_oen <= frm_rd && (bit_cnt >= 6'd45);
            end
          end else if (frm_rd && (bit_cnt == 6'd47)) begin
            ta_ok <= ~mdio_in;
          end
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
    end
  end

  // Frame shift data, read-data capture and per-register status snapshots.
  always_ff @(posedge clk_50_max10) begin
    if (frm_start)
      frm_sh <= nxt_word[62:0];
    else if (mdc_fall)
      frm_sh <= {frm_sh[61:0], 1'b1};
    if (mdc_rise && frm_rd && (bit_cnt >= 6'd48))
      rd_sh <= {rd_sh[14:0], mdio_in};
    if (frm_done && (state == RD_BMSR)) begin
      bmsr_link <= rd_sh[2];
      bmsr_ok   <= ta_ok;
    end
    if (frm_done && (state == RD_PSSR)) begin
      pssr_link <= rd_sh[11] & rd_sh[10];
      pssr_spd  <= rd_sh[15:14];
      pssr_ok   <= ta_ok;
    end
  end

  // MAC speed-force strobes follow the reported status one cycle later.
  always_ff @(posedge clk_50_max10 or negedge resetn) begin
    if (!resetn) begin
      set_1000 <= 1'b0;
      set_10   <= 1'b0;
    end else if (!phy_resetn) begin
      set_1000 <= 1'b0;
      set_10   <= 1'b0;
    end else begin
      set_1000 <= link_up && (speed == 2'b10);
      set_10   <= link_up && (speed == 2'b00);
    end
  end

endmodule

// File: tb/tb_phy_link_manager.sv
// Bench for phy_link_manager: a small MDIO PHY model answers read frames,
// a table of register values drives the status checks, and hand-written
// sequences cover PHY reset abort and restart.
module tb_phy_link_manager;

  localparam int          MDC_DIV    = 2;
  localparam logic [4:0]  PHY_ADDR   = 5'd3;
  localparam int          SETTLE_CYC = 20;
  localparam int          POLL_CYC   = 200;
  localparam logic [15:0] CTRL_VAL   = 16'h1340;

  logic clk_50_max10 = 1'b0;
  logic resetn = 1'b0, phy_resetn = 1'b0, restart = 1'b0;
  logic mdc, mdio_out, mdio_oen, link_up, set_1000, set_10, cfg_done, mdio_err;
  logic [1:0] speed;
  logic mdio_in = 1'b1;

  always #10 clk_50_max10 = ~clk_50_max10;

  phy_link_manager #(
    .MDC_DIV(MDC_DIV), .PHY_ADDR(PHY_ADDR), .SETTLE_CYC(SETTLE_CYC),
    .POLL_CYC(POLL_CYC), .CTRL_VAL(CTRL_VAL)
  ) dut (
    .clk_50_max10(clk_50_max10), .resetn(resetn), .phy_resetn(phy_resetn),
    .restart(restart), .mdc(mdc), .mdio_out(mdio_out), .mdio_oen(mdio_oen),
    .mdio_in(mdio_in), .link_up(link_up), .speed(speed), .set_1000(set_1000),
    .set_10(set_10), .cfg_done(cfg_done), .mdio_err(mdio_err)
  );

  typedef struct {
    logic [63:0] word;
    logic [63:0] omask;
    int          pre_ones;
    bit          pre_bad;
  } frame_t;

  typedef struct {
    logic [15:0] bmsr;
    logic [15:0] pssr;
    bit          present;
    logic        link;
    logic [1:0]  spd;
    logic        s1000;
    logic        s10;
    logic        err;
  } vec_t;

  frame_t frames[$];
  vec_t   vt[7];

  // PHY model state
  int          fr_cnt = 0, rd_cnt = 0, pos = 0, ones = 0, nb = 0;
  bit          hunt = 1'b1, st0 = 1'b0, pre_bad = 1'b0, cur_rd = 1'b0, present = 1'b1;
  logic        b;
  logic [63:0] word = '1, omask = '0;
  logic [4:0]  regad = '0;
  logic [15:0] rv;
  logic [15:0] bmsr_val = 16'h796D, pssr_val = 16'hAC00;

  // PHY model: decodes frames on MDC rising edges and drives the next read bit.
  always @(posedge mdc or negedge phy_resetn) begin
    if (!phy_resetn) begin
      hunt = 1'b1; st0 = 1'b0; ones = 0; pre_bad = 1'b0; mdio_in = 1'b1;
    end else begin
      b = mdio_oen ? mdio_in : mdio_out;
      if (hunt) begin
        if (mdio_oen) pre_bad = 1'b1;
        if (st0) begin
          if (b) begin
            hunt = 1'b0; pos = 33; word = '1; word[31:30] = 2'b01; omask = '0; cur_rd = 1'b0;
          end
        end else if (b) ones++;
        else st0 = 1'b1;
      end else begin
        pos++;
        word[63-pos]  = b;
        omask[63-pos] = mdio_oen;
        if (pos == 35) cur_rd = (word[29:28] == 2'b10);
        if (pos == 45) regad = word[22:18];
        if (pos == 63) begin
          frames.push_back('{word: word, omask: omask, pre_ones: ones, pre_bad: pre_bad});
          fr_cnt++;
          if (cur_rd) rd_cnt++;
          hunt = 1'b1; st0 = 1'b0; ones = 0; pre_bad = 1'b0; mdio_in = 1'b1;
        end else begin
          nb = pos + 1;
          rv = (regad == 5'd1) ? bmsr_val : ((regad == 5'd17) ? pssr_val : 16'hFFFF);
          if (cur_rd && present && nb == 47) mdio_in = 1'b0;
          else if (cur_rd && present && nb >= 48) mdio_in = rv[63-nb];
          else mdio_in = 1'b1;
        end
      end
    end
  end

  // Pad outputs may only move on the cycle MDC falls (or while MDC stays low).
  logic prev_out = 1'b1, prev_oen = 1'b1;
  int   edge_viol = 0;
  always @(negedge clk_50_max10) begin
    if (((mdio_out !== prev_out) || (mdio_oen !== prev_oen)) && (mdc === 1'b1)) edge_viol++;
    prev_out = mdio_out;
    prev_oen = mdio_oen;
  end

  int n_chk = 0, n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_50_max10);
  endtask

  task automatic wait_frames(input int target, input int budget, input string name);
    int i = 0;
    while (fr_cnt < target && i < budget) begin @(negedge clk_50_max10); i++; end
    check(name, 64'(fr_cnt >= target), 64'd1);
  endtask

  task automatic wait_reads(input int target, input int budget, input string name);
    int i = 0;
    while (rd_cnt < target && i < budget) begin @(negedge clk_50_max10); i++; end
    check(name, 64'(rd_cnt >= target), 64'd1);
  endtask

  // Cycles from now until mdio_oen goes low, capped at budget.
  task automatic cycles_to_frame(input int budget, output int k);
    k = 0;
    while (mdio_oen !== 1'b0 && k < budget) begin @(negedge clk_50_max10); k++; end
  endtask

  function automatic logic [63:0] exp_wr();
    return {32'hFFFF_FFFF, 2'b01, 2'b01, PHY_ADDR, 5'd0, 2'b10, CTRL_VAL};
  endfunction

  function automatic logic [45:0] exp_rd_hdr(input logic [4:0] r);
    return {32'hFFFF_FFFF, 2'b01, 2'b10, PHY_ADDR, r};
  endfunction

  task automatic check_write(input string tag);
    frame_t f;
    if (frames.size() > 0) begin
      f = frames.pop_front();
      check({tag, "_word"}, f.word, exp_wr());
      check({tag, "_oen"}, f.omask, 64'd0);
      check({tag, "_pre"}, 64'(f.pre_ones), 64'd32);
      check({tag, "_preoen"}, 64'(f.pre_bad), 64'd0);
    end
  endtask

  task automatic check_read_pair(input string tag);
    frame_t f;
    if (frames.size() >= 2) begin
      f = frames.pop_front();
      check({tag, "_bmsr_hdr"}, 64'(f.word[63:18]), 64'(exp_rd_hdr(5'd1)));
      check({tag, "_bmsr_oen"}, f.omask, 64'h3FFFF);
      f = frames.pop_front();
      check({tag, "_pssr_hdr"}, 64'(f.word[63:18]), 64'(exp_rd_hdr(5'd17)));
      check({tag, "_pssr_oen"}, f.omask, 64'h3FFFF);
    end
  endtask

  initial begin
    int k, base;
    vt[0] = '{16'h796D, 16'hAC00, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0};
    vt[1] = '{16'h796D, 16'h0C00, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0};
    vt[2] = '{16'h796D, 16'h4C00, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0};
    vt[3] = '{16'h796D, 16'hEC00, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0};
    vt[4] = '{16'h7969, 16'hAC00, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0};
    vt[5] = '{16'h796D, 16'hAC00, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1};
    vt[6] = '{16'h796D, 16'h4C00, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0};

    // reset state
    cyc(3);
    check("rst_mdc", 64'(mdc), 64'd0);
    check("rst_mdio_out", 64'(mdio_out), 64'd1);
    check("rst_mdio_oen", 64'(mdio_oen), 64'd1);
    check("rst_link", 64'(link_up), 64'd0);
    check("rst_speed", 64'(speed), 64'd0);
    check("rst_set", 64'({set_1000, set_10}), 64'd0);
    check("rst_cfg_done", 64'(cfg_done), 64'd0);
    check("rst_err", 64'(mdio_err), 64'd0);
    resetn = 1'b1;
    cyc(5);
    check("idle_oen", 64'(mdio_oen), 64'd1);

    // bring-up: settle then control write
    phy_resetn = 1'b1;
    cycles_to_frame(500, k);
    check("settle_lat", 64'(k), 64'(SETTLE_CYC + 1));
    check("wr_start_cfg", 64'(cfg_done), 64'd0);
    wait_frames(1, 600, "wr_timeout");
    check_write("wr");
    cyc(MDC_DIV + 2);
    check("wr_cfg_done", 64'(cfg_done), 64'd1);
    check("wr_link", 64'(link_up), 64'd0);

    // polling table
    for (int v = 0; v < 7; v++) begin
      bmsr_val = vt[v].bmsr;
      pssr_val = vt[v].pssr;
      present  = vt[v].present;
      base = rd_cnt;
      wait_reads(base + 2, 2000, $sformatf("v%0d_timeout", v));
      check_read_pair($sformatf("v%0d", v));
      cyc(MDC_DIV + 4);
      check($sformatf("v%0d_link", v), 64'(link_up), 64'(vt[v].link));
      check($sformatf("v%0d_speed", v), 64'(speed), 64'(vt[v].spd));
      check($sformatf("v%0d_set_1000", v), 64'(set_1000), 64'(vt[v].s1000));
      check($sformatf("v%0d_set_10", v), 64'(set_10), 64'(vt[v].s10));
      check($sformatf("v%0d_err", v), 64'(mdio_err), 64'(vt[v].err));
    end

    // PHY reset at bit 40 of a read frame
    k = 0;
    while (!(!hunt && cur_rd && pos == 40) && k < 1500) begin @(negedge clk_50_max10); k++; end
    check("abort_reach", 64'(!hunt && cur_rd && pos == 40), 64'd1);
    phy_resetn = 1'b0;
    cyc(1);
    check("abort_oen", 64'(mdio_oen), 64'd1);
    check("abort_mdc", 64'(mdc), 64'd0);
    check("abort_link", 64'(link_up), 64'd0);
    check("abort_set", 64'({set_1000, set_10}), 64'd0);
    check("abort_cfg_done", 64'(cfg_done), 64'd0);
    check("abort_speed_held", 64'(speed), 64'd1);
    check("abort_err_held", 64'(mdio_err), 64'd0);
    cyc(10);
    frames.delete();
    base = fr_cnt;
    phy_resetn = 1'b1;
    cycles_to_frame(500, k);
    check("resettle_lat", 64'(k), 64'(SETTLE_CYC + 1));
    wait_frames(base + 1, 600, "rewr_timeout");
    check_write("rewr");
    cyc(MDC_DIV + 2);
    check("rewr_cfg_done", 64'(cfg_done), 64'd1);

    // restart during RD_BMSR
    k = 0;
    while (!(!hunt && cur_rd && pos >= 36) && k < 1500) begin @(negedge clk_50_max10); k++; end
    check("rst_rd_reach", 64'(!hunt && cur_rd), 64'd1);
    restart = 1'b1;
    cyc(1);
    restart = 1'b0;
    base = rd_cnt;
    wait_reads(base + 2, 1000, "rs_timeout");
    check_read_pair("rs");
    base = fr_cnt;
    cycles_to_frame(POLL_CYC + 100, k);
    check("rs_gap", 64'(k < 20), 64'd1);
    check("rs_update_link", 64'(link_up), 64'd1);
    check("rs_cfg_clr", 64'(cfg_done), 64'd0);
    wait_frames(base + 1, 600, "rs_wr_timeout");
    check_write("rswr");
    cyc(MDC_DIV + 2);
    check("rs_cfg_done", 64'(cfg_done), 64'd1);

    check("edge_viol", 64'(edge_viol), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
